// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first for a programmable number of frames,
// with idle-zero gaps between frames and an optional corrupted last bit in the first frame.
module sequence_generator #(
  parameter int                PAT_W      = 4,
  parameter logic [PAT_W-1:0]  PATTERN    = 4'b1100,
  parameter int                GAP_CYCLES = 2,
  parameter int                CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_repeat_cnt,
  input  logic             i_corrupt,
  input  logic             i_abort,
  output logic             o_tx_out,
  output logic             o_tx_valid,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_done,
  output logic             o_aborted,
  output logic             o_cfg_err,
  output logic [CNT_W-1:0] o_frames_sent
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           r_state, w_state;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [GAP_W-1:0] r_gap, w_gap;
  logic [CNT_W-1:0] r_rep, w_rep;
  logic             r_corrupt, w_corrupt;
  logic [CNT_W-1:0] r_frames_sent, w_frames_sent;
  logic             r_tx_out, w_tx_out;
  logic             r_tx_valid, w_tx_valid;
  logic             r_busy, w_busy;
  logic             r_frame_done, w_frame_done;
  logic             r_done, w_done;
  logic             r_aborted, w_aborted;
  logic             r_cfg_err, w_cfg_err;
  logic             w_last_frame;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

  // Bits are indexed counting down, so the current bit is simply PATTERN[idx] and idx==0 is the last.
  assign w_last_frame = ((CNT_W+1)'(r_frames_sent) + (CNT_W+1)'(1)) >= (CNT_W+1)'(r_rep);

  always_comb begin
    w_state       = r_state;
    w_idx         = r_idx;
    w_gap         = r_gap;
    w_rep         = r_rep;
    w_corrupt     = r_corrupt;
    w_frames_sent = r_frames_sent;
    w_tx_out      = 1'b0;
    w_tx_valid    = 1'b0;
    w_busy        = 1'b0;
    w_frame_done  = 1'b0;
    w_done        = 1'b0;
    w_aborted     = 1'b0;
    w_cfg_err     = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_repeat_cnt != '0) begin
            w_state       = SEND;
            w_idx         = IDX_FIRST;
            w_gap         = '0;
            w_rep         = i_repeat_cnt;
            w_corrupt     = i_corrupt;
            w_frames_sent = '0;
          end else begin
            w_cfg_err = 1'b1;
          end
        end
      end
      SEND: begin
        if (i_abort) begin
          w_state   = IDLE;
          w_idx     = '0;
          w_gap     = '0;
          w_aborted = 1'b1;
        end else if (r_idx == '0) begin
          w_frames_sent = sat_inc(r_frames_sent);
          if (w_last_frame) begin
            w_state = DONE;
          end else if (GAP_CYCLES == 0) begin
            w_idx = IDX_FIRST;
          end else begin
            w_state = GAP;
            w_gap   = '0;
          end
        end else begin
          w_idx = r_idx - IDX_W'(1);
        end
      end
      GAP: begin
        if (i_abort) begin
          w_state   = IDLE;
          w_idx     = '0;
          w_gap     = '0;
          w_aborted = 1'b1;
        end else if (r_gap == GAP_LAST) begin
          w_state = SEND;
          w_idx   = IDX_FIRST;
          w_gap   = '0;
        end else begin
          w_gap = r_gap + GAP_W'(1);
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase

    // Outputs are derived from the upcoming state so every output is a plain register.
    if (w_state == SEND) begin
      w_tx_valid   = 1'b1;
      w_frame_done = (w_idx == '0);
      w_tx_out     = PATTERN[w_idx] ^ (w_corrupt && (w_idx == '0) && (w_frames_sent == '0));
    end
    w_busy = (w_state != IDLE);
    w_done = (w_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_gap         <= '0;
      r_rep         <= '0;
      r_corrupt     <= 1'b0;
      r_frames_sent <= '0;
      r_tx_out      <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_idx         <= w_idx;
      r_gap         <= w_gap;
      r_rep         <= w_rep;
      r_corrupt     <= w_corrupt;
      r_frames_sent <= w_frames_sent;
      r_tx_out      <= w_tx_out;
      r_tx_valid    <= w_tx_valid;
      r_busy        <= w_busy;
      r_frame_done  <= w_frame_done;
      r_done        <= w_done;
      r_aborted     <= w_aborted;
      r_cfg_err     <= w_cfg_err;
    end
  end

  assign o_tx_out      = r_tx_out;
  assign o_tx_valid    = r_tx_valid;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_done        = r_done;
  assign o_aborted     = r_aborted;
  assign o_cfg_err     = r_cfg_err;
  assign o_frames_sent = r_frames_sent;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: per-cycle vector table fed through an expected-output queue,
// plus hand-written sequences for mid-run reset and a full-length run.
`timescale 1ns/1ps
module tb_sequence_generator;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [CNT_W-1:0] i_repeat_cnt = '0;
  logic             i_corrupt = 1'b0;
  logic             i_abort = 1'b0;
  logic             o_tx_out, o_tx_valid, o_busy, o_frame_done, o_done, o_aborted, o_cfg_err;
  logic [CNT_W-1:0] o_frames_sent;

  sequence_generator #(
    .PAT_W(4), .PATTERN(4'b1100), .GAP_CYCLES(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_repeat_cnt(i_repeat_cnt),
    .i_corrupt(i_corrupt), .i_abort(i_abort), .o_tx_out(o_tx_out), .o_tx_valid(o_tx_valid),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_done(o_done), .o_aborted(o_aborted),
    .o_cfg_err(o_cfg_err), .o_frames_sent(o_frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic tx; logic vld; logic busy; logic fd; logic dn; logic ab; logic ce;
    logic [CNT_W-1:0] fs;
  } out_t;

  typedef struct {
    logic st; logic [CNT_W-1:0] rep; logic cor; logic abt; out_t exp;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic out_t dut_out();
    return {o_tx_out, o_tx_valid, o_busy, o_frame_done, o_done, o_aborted, o_cfg_err, o_frames_sent};
  endfunction

  task automatic cmp(input string name, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got tx=%b vld=%b busy=%b fd=%b done=%b abt=%b cfg=%b fs=%0d, want tx=%b vld=%b busy=%b fd=%b done=%b abt=%b cfg=%b fs=%0d",
               name, act.tx, act.vld, act.busy, act.fd, act.dn, act.ab, act.ce, act.fs,
               exp.tx, exp.vld, exp.busy, exp.fd, exp.dn, exp.ab, exp.ce, exp.fs);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One table row: inputs held for one cycle, outputs expected after that cycle's rising edge.
  task automatic rr(input bit st, input int rep, input bit cor, input bit abt,
                    input bit tx, input bit vld, input bit bsy, input bit fd,
                    input bit dn, input bit ab, input bit ce, input int fs);
    vec_t v;
    v.st = st; v.rep = CNT_W'(rep); v.cor = cor; v.abt = abt;
    v.exp = {tx, vld, bsy, fd, dn, ab, ce, CNT_W'(fs)};
    tbl.push_back(v);
  endtask

  task automatic frm(input int fs, input bit last_bit, input bit st, input int rep, input bit cor);
    rr(st, rep, cor, 0, 1, 1, 1, 0, 0, 0, 0, fs);
    rr(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, fs);
    rr(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, fs);
    rr(0, 0, 0, 0, last_bit, 1, 1, 1, 0, 0, 0, fs);
  endtask

  task automatic gp(input int fs);
    rr(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, fs);
  endtask

  task automatic dn(input int fs);
    rr(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, fs);
  endtask

  task automatic idle(input int fs);
    rr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fs);
  endtask

  task automatic apply(input int a, input int b);
    out_t act, exp;
    for (int i = a; i < b; i++) begin
      @(negedge clk);
      i_start = tbl[i].st; i_repeat_cnt = tbl[i].rep; i_corrupt = tbl[i].cor; i_abort = tbl[i].abt;
      exp_q.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      act = dut_out();
      exp = exp_q.pop_front();
      cmp($sformatf("row%0d", i), act, exp);
    end
    @(negedge clk);
    i_start = 0; i_repeat_cnt = '0; i_corrupt = 0; i_abort = 0;
  endtask

  int t1a, t1b, t2b, t3b, t4b, t4c, t5b;
  int fd_cnt;
  bit seen_done;

  initial begin
    // Test 1: single frame
    t1a = tbl.size();
    frm(0, 0, 1, 1, 0); dn(1); idle(1);
    t1b = tbl.size();
    // Test 2: three frames with gaps
    frm(0, 0, 1, 3, 0); gp(1); gp(1); frm(1, 0, 0, 0, 0); gp(2); gp(2);
    frm(2, 0, 0, 0, 0); dn(3); idle(3);
    t2b = tbl.size();
    // Test 3: corrupted first frame
    frm(0, 1, 1, 2, 1); gp(1); gp(1); frm(1, 0, 0, 0, 0); dn(2); idle(2);
    t3b = tbl.size();
    // Test 4: abort on bit 2 of frame 2
    frm(0, 0, 1, 3, 0); gp(1); gp(1);
    rr(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
    rr(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
    rr(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1); idle(1);
    t4b = tbl.size();
    // Abort in the gap
    frm(0, 0, 1, 2, 0); gp(1);
    rr(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    t4c = tbl.size();
    // Test 5: cfg error, abort ignored in IDLE, start beats abort, start/abort ignored while busy/DONE
    rr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    rr(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    rr(1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    rr(1, 2, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    rr(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    rr(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    dn(1);
    rr(1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    t5b = tbl.size();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", dut_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(t1a, t5b);

    // Test 6: asynchronous reset during GAP
    @(negedge clk);
    i_start = 1; i_repeat_cnt = 4'd3;
    @(negedge clk);
    i_start = 0; i_repeat_cnt = '0;
    repeat (4) @(negedge clk);
    #1;
    chk_bit("gap_valid_low", o_tx_valid, 1'b0);
    chk_bit("gap_busy", o_busy, 1'b1);
    chk_int("gap_frames", int'(o_frames_sent), 1);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("async_reset", dut_out(), '0);
    @(negedge clk);
    cmp("reset_held", dut_out(), '0);
    rst_n = 1'b1;
    apply(t1a, t1b);

    // Full-length run reaches the largest frame count
    @(negedge clk);
    i_start = 1; i_repeat_cnt = 4'd15;
    @(negedge clk);
    i_start = 0; i_repeat_cnt = '0;
    fd_cnt = 0;
    seen_done = 0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (o_frame_done) fd_cnt++;
      if (o_done) seen_done = 1;
      @(negedge clk);
    end
    chk_bit("run15_done_seen", seen_done, 1'b1);
    chk_int("run15_frame_done_pulses", fd_cnt, 15);
    chk_int("run15_frames_sent", int'(o_frames_sent), 15);
    @(negedge clk);
    chk_bit("run15_idle_busy", o_busy, 1'b0);
    chk_int("run15_frames_hold", int'(o_frames_sent), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
